jvm_fetch_decode_unit: RTL and testbench

//  Front end of the JVM->ARM translator. Three parts:
//  - bytecode fetcher with a handshake; streams JVM bytes from an internal bytecode ROM.
//  - opcode->parameter-count ROM.
//  - address->ARM instruction ROM that holds the translation link-list entries.

---
 rtl/jvm_fetch_decode_unit.sv | 125 ++++++++++++
 tb/tb_jvm_fetch_decode_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jvm_fetch_decode_unit.sv
// Front end of the JVM->ARM translator: handshaked bytecode fetcher over an internal
// bytecode ROM, opcode operand-count decoder, and the ARM translation ROM lookup.
module jvm_fetch_decode_unit #(
  parameter int    ADDRESS_WIDTH    = 16,
  parameter int    ADR_ROM_ADR_SIZE = 8,
  parameter int    PARAM_LEN        = 2,
  parameter int    FETCH_LATENCY    = 2,
  parameter string BYTECODE_FILE    = "bytecode.hex",
  parameter string ARM_ROM_FILE     = "arm_rom.hex"
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pc_reset,
  input  logic [ADDRESS_WIDTH-1:0]    pc_reset_value,
  input  logic                        start,
  output logic                        ready,
  output logic [7:0]                  next_byte,
  input  logic [7:0]                  opcode,
  output logic [PARAM_LEN-1:0]        count,
  input  logic [ADR_ROM_ADR_SIZE-1:0] i,
  output logic [31:0]                 arm_inst
);

  localparam int MEM_DEPTH = 1 << ADDRESS_WIDTH;
  localparam int ROM_DEPTH = 1 << ADR_ROM_ADR_SIZE;
  localparam int CNT_W     = (FETCH_LATENCY > 1) ? $clog2(FETCH_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FETCH_LATENCY - 1);
  localparam logic [31:0]      ARM_NOP  = 32'hE1A00000;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } fetch_state_e;

  logic [7:0]  bytecode_mem [MEM_DEPTH];
  logic [31:0] arm_rom      [ROM_DEPTH];

  // Entries of the ARM image that are never supplied must read as NOP.
  initial begin
    for (int k = 0; k < ROM_DEPTH; k++) arm_rom[k] = ARM_NOP;
  end

  fetch_state_e             state_q,     state_d;
  logic [CNT_W-1:0]         cnt_q,       cnt_d;
  logic [ADDRESS_WIDTH-1:0] pc_q,        pc_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,      addr_d;
  logic [7:0]               next_byte_q, next_byte_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    next_byte_d = next_byte_q;

    if (pc_reset) begin
      // Same effect as reset; any fetch in flight is dropped.
      state_d     = S_IDLE;
      cnt_d       = '0;
      pc_d        = pc_reset_value;
      next_byte_d = 8'h00;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_BUSY;
            cnt_d   = CNT_LOAD;
            addr_d  = pc_q;
            pc_d    = pc_q + 1'b1;
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            state_d     = S_IDLE;
            next_byte_d = bytecode_mem[addr_q];
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the ROM arrays are deliberately outside reset; only control and data registers clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pc_q        <= pc_reset_value;
      addr_q      <= '0;
      next_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      next_byte_q <= next_byte_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign next_byte = next_byte_q;

  logic [1:0] count_raw;

  always_comb begin
    count_raw = 2'd0;
    case (opcode) inside
      8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
        count_raw = 2'd1;
      8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
      8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
        count_raw = 2'd2;
      default:
        count_raw = 2'd0;
    endcase
  end

  assign count    = PARAM_LEN'(count_raw);
  assign arm_inst = arm_rom[i];

endmodule

// File: tb/tb_jvm_fetch_decode_unit.sv
// Self-checking bench for jvm_fetch_decode_unit: transaction-level fetch model over a
// random bytecode image, table model of operand counts, and a sparse ARM ROM model.
module tb_jvm_fetch_decode_unit;

  localparam int AW  = 16;
  localparam int RW  = 8;
  localparam int PL  = 2;
  localparam int LAT = 2;
  localparam int MEM_SIZE = 1 << AW;
  localparam int ROM_SIZE = 1 << RW;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic          clk = 1'b0;
  logic          reset;
  logic          pc_reset;
  logic [AW-1:0] pc_reset_value;
  logic          start;
  logic          ready;
  logic [7:0]    next_byte;
  logic [7:0]    opcode;
  logic [PL-1:0] count;
  logic [RW-1:0] i;
  logic [31:0]   arm_inst;

  jvm_fetch_decode_unit #(
    .ADDRESS_WIDTH   (AW),
    .ADR_ROM_ADR_SIZE(RW),
    .PARAM_LEN       (PL),
    .FETCH_LATENCY   (LAT),
    .BYTECODE_FILE   (""),
    .ARM_ROM_FILE    ("")
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_reset      (pc_reset),
    .pc_reset_value(pc_reset_value),
    .start         (start),
    .ready         (ready),
    .next_byte     (next_byte),
    .opcode        (opcode),
    .count         (count),
    .i             (i),
    .arm_inst      (arm_inst)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: image contents, next PC to be fetched, last delivered byte.
  logic [7:0]  model_mem [MEM_SIZE];
  logic [31:0] model_rom [ROM_SIZE];
  logic [1:0]  model_count [256];
  int          model_pc;
  logic [7:0]  model_byte;

  function automatic logic [7:0] model_fetch();
    logic [7:0] b;
    b          = model_mem[model_pc];
    model_pc   = (model_pc + 1) % MEM_SIZE;
    model_byte = b;
    return b;
  endfunction

  function automatic void model_load_pc(input int v);
    model_pc   = v % MEM_SIZE;
    model_byte = 8'h00;
  endfunction

  function automatic void set_count_range(input int lo, input int hi, input logic [1:0] v);
    for (int k = lo; k <= hi; k++) model_count[k] = v;
  endfunction

  // Issues one start at a negedge where ready is high and waits (bounded) for completion.
  // When hold is clear, start is toggled randomly while busy; those pulses must be ignored.
  task automatic fetch(input bit hold, output logic [7:0] got, output int lat);
    start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (ready !== 1'b1 && lat < 50) begin
      lat++;
      if (!hold) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
    got = next_byte;
  endtask

  task automatic pulse_pc_reset(input logic [AW-1:0] v);
    pc_reset_value = v;
    pc_reset       = 1'b1;
    @(negedge clk);
    pc_reset       = 1'b0;
    model_load_pc(int'(v));
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    pc_reset_value = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_load_pc(0);
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: ready=%b expected 1", ready);
    end
    checks++;
    if (next_byte !== 8'h00) begin
      failures++; $display("FAIL reset_next_byte: next_byte=%02h expected 00", next_byte);
    end
  endtask

  task automatic test_first_fetch();
    logic [7:0] got, exp;
    int lat;
    for (int n = 0; n < 2; n++) begin
      exp = model_fetch();
      fetch(1'b0, got, lat);
      checks++;
      if (lat != LAT) begin
        failures++; $display("FAIL first_fetch_latency[%0d]: cycles=%0d expected %0d", n, lat, LAT);
      end
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL first_fetch_byte[%0d]: next_byte=%02h expected %02h", n, got, exp);
      end
    end
  endtask

  task automatic test_hold_start();
    logic [7:0] got, exp;
    int lat;
    pulse_pc_reset(16'h0000);
    for (int n = 0; n < 3; n++) begin
      exp = model_fetch();
      fetch(1'b1, got, lat);
      checks++;
      if (lat != LAT || got !== exp) begin
        failures++;
        $display("FAIL hold_start[%0d]: next_byte=%02h after %0d cycles, expected %02h after %0d",
                 n, got, lat, exp, LAT);
      end
    end
    start = 1'b0;
    @(negedge clk);
    // pc must now be 3; random start pulses while busy must not advance it.
    for (int n = 0; n < 2; n++) begin
      exp = model_fetch();
      fetch(1'b0, got, lat);
      checks++;
      if (lat != LAT || got !== exp) begin
        failures++;
        $display("FAIL after_hold[%0d]: next_byte=%02h after %0d cycles, expected %02h after %0d",
                 n, got, lat, exp, LAT);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got, exp;
    int lat;
    pulse_pc_reset(16'hFFFF);
    checks++;
    if (ready !== 1'b1 || next_byte !== 8'h00) begin
      failures++; $display("FAIL wrap_load: ready=%b next_byte=%02h expected 1/00", ready, next_byte);
    end
    for (int n = 0; n < 2; n++) begin
      exp = model_fetch();
      fetch(1'b0, got, lat);
      checks++;
      if (lat != LAT || got !== exp) begin
        failures++;
        $display("FAIL wrap_fetch[%0d]: next_byte=%02h after %0d cycles, expected %02h after %0d",
                 n, got, lat, exp, LAT);
      end
    end
  endtask

  task automatic test_pc_reset_midfetch();
    logic [7:0] got, exp;
    int lat;
    pulse_pc_reset(16'h1234);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL midfetch_busy: ready=%b expected 0", ready);
    end
    // start asserted together with pc_reset must lose to it.
    start = 1'b1;
    pulse_pc_reset(16'h0200);
    start = 1'b0;
    checks++;
    if (ready !== 1'b1 || next_byte !== 8'h00) begin
      failures++;
      $display("FAIL midfetch_abort: ready=%b next_byte=%02h expected 1/00", ready, next_byte);
    end
    repeat (LAT + 1) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || next_byte !== 8'h00) begin
      failures++;
      $display("FAIL midfetch_no_late_write: ready=%b next_byte=%02h expected 1/00", ready, next_byte);
    end
    exp = model_fetch();
    fetch(1'b0, got, lat);
    checks++;
    if (lat != LAT || got !== exp) begin
      failures++;
      $display("FAIL midfetch_refetch: next_byte=%02h after %0d cycles, expected %02h after %0d",
               got, lat, exp, LAT);
    end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    int lat, op, k;
    logic [AW-1:0] v;
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 6) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp = model_fetch();
        fetch(1'b0, got, lat);
        checks++;
        if (lat != LAT || got !== exp) begin
          failures++;
          $display("FAIL random_fetch[%0d]: next_byte=%02h after %0d cycles, expected %02h after %0d",
                   n, got, lat, exp, LAT);
        end
      end else begin
        v = (op == 8) ? AW'(16'hFFFE + $urandom_range(0, 1)) : AW'($urandom);
        if (op == 9) begin
          k = int'($urandom_range(0, LAT - 1));
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          repeat (k) @(negedge clk);
        end
        start = 1'($urandom_range(0, 1));
        pulse_pc_reset(v);
        start = 1'b0;
        checks++;
        if (ready !== 1'b1 || next_byte !== model_byte) begin
          failures++;
          $display("FAIL random_pc_reset[%0d]: ready=%b next_byte=%02h expected 1/%02h",
                   n, ready, next_byte, model_byte);
        end
      end
    end
  endtask

  task automatic test_count();
    for (int k = 0; k < 256; k++) model_count[k] = 2'd0;
    set_count_range(8'h10, 8'h10, 2'd1);
    set_count_range(8'h11, 8'h11, 2'd2);
    set_count_range(8'h12, 8'h12, 2'd1);
    set_count_range(8'h13, 8'h14, 2'd2);
    set_count_range(8'h15, 8'h19, 2'd1);
    set_count_range(8'h36, 8'h3A, 2'd1);
    set_count_range(8'h84, 8'h84, 2'd2);
    set_count_range(8'h99, 8'hA8, 2'd2);
    set_count_range(8'hA9, 8'hA9, 2'd1);
    set_count_range(8'hB2, 8'hB8, 2'd2);
    set_count_range(8'hBB, 8'hBB, 2'd2);
    set_count_range(8'hBC, 8'hBC, 2'd1);
    set_count_range(8'hBD, 8'hBD, 2'd2);
    set_count_range(8'hC0, 8'hC1, 2'd2);
    set_count_range(8'hC6, 8'hC7, 2'd2);
    for (int k = 0; k < 256; k++) begin
      opcode = 8'(k);
      #1;
      checks++;
      if (count !== model_count[k]) begin
        failures++; $display("FAIL count[%02h]: count=%0d expected %0d", k, count, model_count[k]);
      end
    end
  endtask

  task automatic check_rom_all(input string tag);
    for (int k = 0; k < ROM_SIZE; k++) begin
      i = RW'(k);
      #1;
      checks++;
      if (arm_inst !== model_rom[k]) begin
        failures++;
        $display("FAIL %s[%0d]: arm_inst=%08h expected %08h", tag, k, arm_inst, model_rom[k]);
      end
    end
  endtask

  task automatic test_arm_rom();
    check_rom_all("arm_rom");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_load_pc(int'(pc_reset_value));
    check_rom_all("arm_rom_after_reset");
  endtask

  initial begin
    reset          = 1'b1;
    pc_reset       = 1'b0;
    pc_reset_value = '0;
    start          = 1'b0;
    opcode         = 8'h00;
    i              = '0;
    model_pc       = 0;
    model_byte     = 8'h00;
    #1;
    // Images are generated here and written straight into the design's ROM arrays.
    for (int k = 0; k < MEM_SIZE; k++) model_mem[k] = 8'($urandom);
    model_mem[0] = 8'h10;
    model_mem[1] = 8'h05;
    model_mem[2] = 8'h60;
    for (int k = 0; k < MEM_SIZE; k++) dut.bytecode_mem[k] = model_mem[k];
    for (int k = 0; k < ROM_SIZE; k++) model_rom[k] = NOP;
    model_rom[3] = 32'hE52D0004;
    for (int n = 0; n < 6; n++) model_rom[$urandom_range(8, ROM_SIZE - 1)] = $urandom;
    for (int k = 0; k < ROM_SIZE; k++) if (model_rom[k] !== NOP) dut.arm_rom[k] = model_rom[k];
    @(negedge clk);

    test_reset();
    test_first_fetch();
    test_hold_start();
    test_wrap();
    test_pc_reset_midfetch();
    test_random();
    test_count();
    test_arm_rom();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
